seq_gen_detect: RTL

Parametrised pseudo-random sequence generator and detector. Every TICK_DIV enabled clocks it advances an internal LFSR by SEQ_W steps to produce a fresh SEQ_W-bit sequence. In the same evaluation it latches a synchronised externally driven sequence (from the Arduino header), compares the two within a programmable Hamming tolerance, and keeps saturating hit/miss/streak statistics for the LED and LCD front-ends.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_gen_detect_if.sv | 29 ++
 rtl/lfsr_core.sv | 35 +++
 rtl/seq_gen_detect.sv | 66 ++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared LFSR defaults and popcount helper for the sequence
// generator/detector and its LED/LCD front-ends.
package seq_pkg;
    localparam logic [15:0] DEF_TAPS = 16'hD008;
    localparam logic [15:0] DEF_SEED = 16'h000F;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/seq_gen_detect_if.sv
// seq_gen_detect_if: control inputs and result/statistics outputs of the
// sequence generator/detector.
interface seq_gen_detect_if #(
    parameter int SEQ_W = 4,
    parameter int LFSR_W = 16,
    parameter int CNT_W = 8
);
    logic en;
    logic reseed;
    logic [SEQ_W-1:0] user_seq;
    logic [LFSR_W-1:0] seed_in;
    logic [SEQ_W-1:0] gen_seq;
    logic [SEQ_W-1:0] user_latched;
    logic match;
    logic tick;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] streak;
    logic [LFSR_W-1:0] lfsr_state;

    modport master(
        output en, reseed, user_seq, seed_in,
        input gen_seq, user_latched, match, tick, hit_cnt, miss_cnt, streak, lfsr_state
    );
    modport slave(
        input en, reseed, user_seq, seed_in,
        output gen_seq, user_latched, match, tick, hit_cnt, miss_cnt, streak, lfsr_state
    );
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR advancing STEPS shifts per strobe, with seed load
// and recovery from the all-zero lockup state.
module lfsr_core import seq_pkg::*; #(
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_TAPS,
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
    parameter int STEPS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state,
    output logic [STEPS-1:0] bits
);
    logic [LFSR_W-1:0] adv;

    // bits[i] is the bit shifted in by step i+1 of the coming advance
    always_comb begin
        adv = state;
        bits = '0;
        for (int i = 0; i < STEPS; i++) begin
            adv = {adv[LFSR_W-2:0], ^(adv & LFSR_TAPS)};
            bits[i] = adv[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEED;
        else if (load) state <= (load_val == '0) ? SEED : load_val;
        else if (state == '0) state <= SEED;
        else if (step) state <= adv;
    end
endmodule

// File: rtl/seq_gen_detect.sv
// seq_gen_detect: periodic LFSR sequence generation compared against a
// synchronised external sequence, with saturating hit/miss/streak statistics.
module seq_gen_detect import seq_pkg::*; #(
    parameter int SEQ_W = 4,
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_TAPS,
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
    parameter int TICK_DIV = 300_000_000,
    parameter int MAX_MISMATCH = 0,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    seq_gen_detect_if.slave bus
);
    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0] div;
    logic [SEQ_W-1:0] sync0, sync1, bits;
    logic term, eval, hit;

    assign term = div == DIV_W'(TICK_DIV - 1);
    // a coincident reseed swallows the evaluation entirely
    assign eval = bus.en & term & ~bus.reseed;
    assign hit = popcount(32'(bits ^ sync1)) <= MAX_MISMATCH;

    lfsr_core #(
        .LFSR_W(LFSR_W), .LFSR_TAPS(LFSR_TAPS), .SEED(SEED), .STEPS(SEQ_W)
    ) u_lfsr (
        .clk(clk), .rst_n(rst_n), .step(eval), .load(bus.reseed),
        .load_val(bus.seed_in), .state(bus.lfsr_state), .bits(bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
            div <= '0;
            bus.tick <= 1'b0;
            bus.gen_seq <= '0;
            bus.user_latched <= '0;
            bus.match <= 1'b0;
            bus.hit_cnt <= '0;
            bus.miss_cnt <= '0;
            bus.streak <= '0;
        end else begin
            sync0 <= bus.user_seq;
            sync1 <= sync0;
            bus.tick <= eval;
            if (bus.reseed) div <= '0;
            else if (bus.en) div <= term ? '0 : div + 1'b1;
            if (eval) begin
                bus.gen_seq <= bits;
                bus.user_latched <= sync1;
                bus.match <= hit;
                if (hit) begin
                    bus.hit_cnt <= &bus.hit_cnt ? bus.hit_cnt : bus.hit_cnt + 1'b1;
                    bus.streak <= &bus.streak ? bus.streak : bus.streak + 1'b1;
                end else begin
                    bus.miss_cnt <= &bus.miss_cnt ? bus.miss_cnt : bus.miss_cnt + 1'b1;
                    bus.streak <= '0;
                end
            end
        end
    end
endmodule
